ciq_entry_ctrl: RTL and testbench
=================================

// Module: ciq_entry_ctrl
// PURPOSE
//  Entry-state owner of the 16-entry compact issue queue (CIQ), directly downstream of the allocation stage.
//  - Drives ciq_free to the allocator and accepts its four free addresses combinationally in the same cycle.
//  - Writes up to DECODE_NUM dispatched uops into the allocated entries.
//  - Clears entries on issue grant or flush, and reports occupancy.
// PARAMETERS
//  DECODE_NUM  4   dispatch lanes per cycle (allocator width)
//  CIQ_DEPTH   16  issue-queue entries
//  ADDR_W      4   entry index width, log2(CIQ_DEPTH)
//  PAYLOAD_W   64  per-uop payload bits stored per entry
// PORTS
//  clk           in   1                     clock; all state changes on rising edge
//  rst_n         in   1                     synchronous reset, active low
//  ciq_free      out  CIQ_DEPTH             ~entry_valid, to allocator
//  free_addr     in   DECODE_NUM*ADDR_W     allocator result; lane i at [i*ADDR_W +: ADDR_W]
//  free_valid    in   DECODE_NUM            free_addr[i] is a genuine free entry
//  disp_valid    in   DECODE_NUM            dispatch request per lane; thermometer from lane 0
//  disp_payload  in   DECODE_NUM*PAYLOAD_W  uop payload per lane
//  disp_ready    out  1                     whole dispatch group accepted this cycle
//  disp_addr     out  DECODE_NUM*ADDR_W     entry assigned to each lane (= free_addr), for rename/ROB tags
//  issue_grant   in   CIQ_DEPTH             entries issued by select this cycle (any count)
//  flush         in   1                     pipeline flush: empty the queue
//  entry_valid   out  CIQ_DEPTH             registered per-entry valid, to wakeup/select
//  entry_payload out  CIQ_DEPTH*PAYLOAD_W   registered per-entry payload
//  ciq_count     out  ADDR_W+1              occupied entries, 0..CIQ_DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//  - entry_valid=0, entry_payload=0, ciq_count=0.
//  - Hence ciq_free = all ones; disp_ready follows the combinational rule below.
//  Combinational path (no register between allocator and this block):
//  - ciq_free = ~entry_valid.
//  - legal = disp_valid in {0000,0001,0011,0111,1111}.
//  - disp_ready = ~flush & legal & (free_valid | ~disp_valid) == all ones.
//  - Acceptance is all-or-nothing; no partial group.
//  - disp_addr = free_addr, passed through unconditionally.
//  - fire = disp_ready & |disp_valid.
//  Next state, priority order:
//  - flush: entry_valid <= 0, ciq_count <= 0. Same-cycle dispatch and grants are dropped.
//  - Otherwise, per entry e:
//    - set_e = fire & some lane i with disp_valid[i] & free_addr[i]==e.
//    - clr_e = issue_grant[e] & entry_valid[e].
//    - entry_valid[e] <= (entry_valid[e] & ~clr_e) | set_e.
//    - payload[e] <= disp_payload of the matching lane when set_e.
//  - set_e and clr_e never coincide: the allocator offers only free entries.
//  - issue_grant on an invalid entry is ignored (no state change; assertion fires).
//  - ciq_count <= ciq_count + popcount(set) - popcount(clr). Unsigned.
//    - Must stay consistent with popcount(entry_valid) in every cycle (assertion).
//  Latency:
//  - A dispatched uop is visible on entry_valid one cycle after fire.
//  - A granted entry reappears in ciq_free one cycle after the grant; there is no same-cycle free bypass.
//  Full / near-full:
//  - With k free entries and a group needing more than k lanes, disp_ready=0.
//  - Upstream holds disp_valid/disp_payload stable and retries.
//  - Full queue: ciq_free=0, free_valid=0, and disp_ready=0 for any nonzero request.
//  Empty request: disp_valid=0 gives disp_ready=1 (when no flush) and no state change.
//  Illegal non-thermometer disp_valid: disp_ready=0, no write. Assertion fires.
//  Reset mid-operation: reset dominates flush, grant and dispatch. The queue is empty on the next cycle.
//  Wrap-around: none. Entry indices are unordered slots; age is tracked elsewhere.
// TESTING
//  1. Reset, then disp_valid=1111 -> disp_ready=1; next cycle entry_valid=000F, ciq_count=4, disp_addr lanes = 0,1,2,3.
//  2. Fill to 14 entries, then request 0111 -> disp_ready=0, no state change.
//     Grant 2 entries -> next cycle the retry is accepted, ciq_count=15.
//  3. entry_valid=FFFF, issue_grant=0x0081 plus dispatch 0011 in the same cycle -> dispatch rejected.
//     Next cycle ciq_free=0x0081 and the same 0011 dispatch fills entries 0 and 7.
//  4. Flush asserted with fire conditions and grants present -> next cycle entry_valid=0, ciq_count=0. Dropped dispatch leaves no payload write.
//  5. disp_valid=0101 with an empty queue -> disp_ready=0, no write, illegal-pattern assertion fires.
//  6. Random dispatch/grant/flush for 10k cycles -> ciq_count==popcount(entry_valid) every cycle.
//     Each stored payload matches its lane's data; no entry is double-allocated.

Source files
------------

// File: rtl/ciq_entry_ctrl.sv
// Entry-state owner of the compact issue queue: accepts allocator free slots combinationally,
// writes dispatched uops into them, clears entries on issue grant or flush and tracks occupancy.
module ciq_entry_ctrl #(
  parameter int DECODE_NUM = 4,
  parameter int CIQ_DEPTH  = 16,
  parameter int ADDR_W     = 4,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [CIQ_DEPTH-1:0]            ciq_free,
  input  logic [DECODE_NUM*ADDR_W-1:0]    free_addr,
  input  logic [DECODE_NUM-1:0]           free_valid,
  input  logic [DECODE_NUM-1:0]           disp_valid,
  input  logic [DECODE_NUM*PAYLOAD_W-1:0] disp_payload,
  output logic                            disp_ready,
  output logic [DECODE_NUM*ADDR_W-1:0]    disp_addr,
  input  logic [CIQ_DEPTH-1:0]            issue_grant,
  input  logic                            flush,
  output logic [CIQ_DEPTH-1:0]            entry_valid,
  output logic [CIQ_DEPTH*PAYLOAD_W-1:0]  entry_payload,
  output logic [ADDR_W:0]                 ciq_count
);

  localparam int CNT_W = ADDR_W + 1;

  logic [CIQ_DEPTH-1:0]  entry_valid_reg;
  logic [CIQ_DEPTH-1:0]  entry_valid_next;
  logic [CIQ_DEPTH-1:0]  set_vec;
  logic [CIQ_DEPTH-1:0]  clr_vec;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [CNT_W-1:0]      set_cnt;
  logic [CNT_W-1:0]      clr_cnt;
  logic [CNT_W-1:0]      valid_cnt;
  logic [DECODE_NUM-1:0] disp_valid_inc;
  logic                  legal;
  logic                  lanes_ok;
  logic                  fire;

  function automatic logic [CNT_W-1:0] popcnt(input logic [CIQ_DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < CIQ_DEPTH; k++) begin
      c = c + CNT_W'(v[k]);
    end
    return c;
  endfunction

  // A thermometer code from lane 0 has no set bit above a clear bit: x & (x+1) == 0.
  assign disp_valid_inc = disp_valid + DECODE_NUM'(1);
  assign legal          = ~|(disp_valid & disp_valid_inc);
  assign lanes_ok       = &(free_valid | ~disp_valid);
  assign disp_ready     = ~flush & legal & lanes_ok;
  assign fire           = disp_ready & (|disp_valid);

  assign disp_addr   = free_addr;
  assign ciq_free    = ~entry_valid_reg;
  assign entry_valid = entry_valid_reg;
  assign ciq_count   = count_reg;

  for (genvar gi = 0; gi < CIQ_DEPTH; gi++) begin : g_entry
    logic                 hit;
    logic [PAYLOAD_W-1:0] data;
    logic [PAYLOAD_W-1:0] payload_reg;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < DECODE_NUM; i++) begin
        if (fire && disp_valid[i] && (free_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
          hit  = 1'b1;
          data = disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end

    assign set_vec[gi] = hit;
    assign entry_payload[gi*PAYLOAD_W +: PAYLOAD_W] = payload_reg;

    // Flush suppresses fire, so a dropped dispatch never touches the payload.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        payload_reg <= '0;
      end else if (hit) begin
        payload_reg <= data;
      end
    end
  end

  assign clr_vec          = issue_grant & entry_valid_reg;
  assign entry_valid_next = (entry_valid_reg & ~clr_vec) | set_vec;
  assign set_cnt          = popcnt(set_vec);
  assign clr_cnt          = popcnt(clr_vec);
  assign valid_cnt        = popcnt(entry_valid_reg);
  assign count_next       = count_reg + set_cnt - clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_valid_reg <= '0;
      count_reg       <= '0;
    end else if (flush) begin
      entry_valid_reg <= '0;
      count_reg       <= '0;
    end else begin
      entry_valid_reg <= entry_valid_next;
      count_reg       <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (legal)
        else $warning("ciq_entry_ctrl: non-thermometer disp_valid %b", disp_valid);
      assert ((issue_grant & ~entry_valid_reg) == '0)
        else $warning("ciq_entry_ctrl: issue_grant on invalid entries %h", issue_grant & ~entry_valid_reg);
      assert (count_reg == valid_cnt)
        else $error("ciq_entry_ctrl: ciq_count %0d disagrees with valid popcount %0d", count_reg, valid_cnt);
    end
  end

endmodule

// File: tb/tb_ciq_entry_ctrl.sv
// Self-checking bench for ciq_entry_ctrl: a reference model of the entry state plus a
// scoreboard of expected payload writes, popped and compared once the DUT has registered them.
module tb_ciq_entry_ctrl;

  localparam int DN = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int PW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [DEPTH-1:0]    ciq_free;
  logic [DN*AW-1:0]    free_addr;
  logic [DN-1:0]       free_valid;
  logic [DN-1:0]       disp_valid;
  logic [DN*PW-1:0]    disp_payload;
  logic                disp_ready;
  logic [DN*AW-1:0]    disp_addr;
  logic [DEPTH-1:0]    issue_grant;
  logic                flush;
  logic [DEPTH-1:0]    entry_valid;
  logic [DEPTH*PW-1:0] entry_payload;
  logic [AW:0]         ciq_count;

  ciq_entry_ctrl #(.DECODE_NUM(DN), .CIQ_DEPTH(DEPTH), .ADDR_W(AW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ciq_free(ciq_free), .free_addr(free_addr),
    .free_valid(free_valid), .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .disp_addr(disp_addr), .issue_grant(issue_grant),
    .flush(flush), .entry_valid(entry_valid), .entry_payload(entry_payload),
    .ciq_count(ciq_count)
  );

  int checks = 0;
  int errors = 0;

  logic [DEPTH-1:0] m_valid;
  logic [PW-1:0]    m_pay [DEPTH];
  logic [AW:0]      m_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;
  wr_t sb[$];

  function automatic logic exp_ready();
    logic ok;
    ok = !flush && (disp_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
    for (int i = 0; i < DN; i++) begin
      if (disp_valid[i] && !free_valid[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic idle();
    disp_valid = '0; free_valid = '0; free_addr = '0;
    issue_grant = '0; flush = 1'b0;
  endtask

  // Allocator model: offer the lowest free entries of the reference state, in lane order.
  task automatic alloc();
    int n;
    n = 0;
    free_addr = '0;
    free_valid = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!m_valid[e] && n < DN) begin
        free_addr[n*AW +: AW] = AW'(e);
        free_valid[n] = 1'b1;
        n++;
      end
    end
  endtask

  task automatic set_payload();
    for (int i = 0; i < DN; i++) disp_payload[i*PW +: PW] = {$urandom, $urandom};
  endtask

  // Updates the reference model for the inputs currently driven, then clocks the DUT.
  task automatic advance();
    logic f;
    logic [DEPTH-1:0] nv;
    logic [AW-1:0] a;
    f = exp_ready() && (disp_valid != '0);
    if (!rst_n) begin
      m_valid = '0;
      for (int e = 0; e < DEPTH; e++) m_pay[e] = '0;
      sb.delete();
    end else if (flush) begin
      m_valid = '0;
    end else begin
      nv = m_valid & ~(issue_grant & m_valid);
      if (f) begin
        for (int i = 0; i < DN; i++) begin
          if (disp_valid[i]) begin
            a = free_addr[i*AW +: AW];
            nv[a] = 1'b1;
            m_pay[a] = disp_payload[i*PW +: PW];
            sb.push_back('{a, disp_payload[i*PW +: PW]});
          end
        end
      end
      m_valid = nv;
    end
    m_count = (AW+1)'($countones(m_valid));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    alloc();
    disp_valid = 4'hF;
    set_payload();
    issue_grant = m_valid;
    advance();
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (entry_valid !== '0) begin errors++; $display("FAIL reset_valid got %h want 0", entry_valid); end
    checks++; if (ciq_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", ciq_count); end
    checks++; if (ciq_free !== 16'hFFFF) begin errors++; $display("FAIL reset_free got %h want ffff", ciq_free); end
    checks++; if (entry_payload !== '0) begin errors++; $display("FAIL reset_payload got nonzero want 0"); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", disp_ready); end
    $display("test_reset done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_first_group();
    wr_t w;
    idle();
    alloc();
    disp_valid = 4'hF;
    set_payload();
    #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got %b want 1", disp_ready); end
    checks++; if (disp_addr !== 16'h3210) begin errors++; $display("FAIL t1_addr got %h want 3210", disp_addr); end
    advance();
    checks++; if (entry_valid !== 16'h000F) begin errors++; $display("FAIL t1_valid got %h want 000f", entry_valid); end
    checks++; if (ciq_count !== 5'd4) begin errors++; $display("FAIL t1_count got %0d want 4", ciq_count); end
    while (sb.size() > 0) begin
      w = sb.pop_front();
      checks++;
      if (entry_payload[w.addr*PW +: PW] !== w.data) begin
        errors++; $display("FAIL t1_payload[%0d] got %h want %h", w.addr, entry_payload[w.addr*PW +: PW], w.data);
      end
    end
    $display("test_first_group done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_near_full();
    wr_t w;
    while (m_count < 12) begin
      idle(); alloc(); disp_valid = 4'hF; set_payload(); advance();
    end
    idle(); alloc(); disp_valid = 4'b0011; set_payload(); advance();
    sb.delete();
    idle(); alloc(); disp_valid = 4'b0111; set_payload();
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_short got %b want 0", disp_ready); end
    advance();
    checks++; if (ciq_count !== 5'd14) begin errors++; $display("FAIL t2_count_hold got %0d want 14", ciq_count); end
    checks++; if (entry_valid !== 16'h3FFF) begin errors++; $display("FAIL t2_valid_hold got %h want 3fff", entry_valid); end
    issue_grant = 16'h0003;
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_grant got %b want 0", disp_ready); end
    advance();
    checks++; if (ciq_count !== 5'd12) begin errors++; $display("FAIL t2_count_grant got %0d want 12", ciq_count); end
    issue_grant = '0;
    alloc();
    #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_retry got %b want 1", disp_ready); end
    checks++; if (disp_addr[11:0] !== 12'hE10) begin errors++; $display("FAIL t2_addr got %h want e10", disp_addr[11:0]); end
    advance();
    checks++; if (ciq_count !== 5'd15) begin errors++; $display("FAIL t2_count_retry got %0d want 15", ciq_count); end
    while (sb.size() > 0) begin
      w = sb.pop_front();
      checks++;
      if (entry_payload[w.addr*PW +: PW] !== w.data) begin
        errors++; $display("FAIL t2_payload[%0d] got %h want %h", w.addr, entry_payload[w.addr*PW +: PW], w.data);
      end
    end
    $display("test_near_full done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_full_grant();
    wr_t w;
    idle(); alloc(); disp_valid = 4'b0001; set_payload(); advance();
    sb.delete();
    checks++; if (entry_valid !== 16'hFFFF) begin errors++; $display("FAIL t3_full got %h want ffff", entry_valid); end
    checks++; if (ciq_free !== 16'h0000) begin errors++; $display("FAIL t3_free_full got %h want 0000", ciq_free); end
    idle(); alloc(); disp_valid = 4'b0011; issue_grant = 16'h0081; set_payload();
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t3_ready_full got %b want 0", disp_ready); end
    advance();
    checks++; if (ciq_free !== 16'h0081) begin errors++; $display("FAIL t3_free_after got %h want 0081", ciq_free); end
    issue_grant = '0;
    alloc();
    #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_retry got %b want 1", disp_ready); end
    checks++; if (disp_addr[7:0] !== 8'h70) begin errors++; $display("FAIL t3_addr got %h want 70", disp_addr[7:0]); end
    advance();
    checks++; if (entry_valid !== 16'hFFFF) begin errors++; $display("FAIL t3_refill got %h want ffff", entry_valid); end
    while (sb.size() > 0) begin
      w = sb.pop_front();
      checks++;
      if (entry_payload[w.addr*PW +: PW] !== w.data) begin
        errors++; $display("FAIL t3_payload[%0d] got %h want %h", w.addr, entry_payload[w.addr*PW +: PW], w.data);
      end
    end
    $display("test_full_grant done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_flush();
    idle(); issue_grant = 16'h000F; advance();
    idle(); alloc(); disp_valid = 4'hF; set_payload(); issue_grant = 16'h00F0; flush = 1'b1;
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t4_ready got %b want 0", disp_ready); end
    advance();
    checks++; if (entry_valid !== '0) begin errors++; $display("FAIL t4_valid got %h want 0", entry_valid); end
    checks++; if (ciq_count !== '0) begin errors++; $display("FAIL t4_count got %0d want 0", ciq_count); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (entry_payload[e*PW +: PW] !== m_pay[e]) begin
        errors++; $display("FAIL t4_payload[%0d] got %h want %h", e, entry_payload[e*PW +: PW], m_pay[e]);
      end
    end
    $display("test_flush done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_illegal();
    idle(); alloc(); disp_valid = 4'b0101; set_payload();
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t5_ready got %b want 0", disp_ready); end
    advance();
    checks++; if (entry_valid !== '0) begin errors++; $display("FAIL t5_valid got %h want 0", entry_valid); end
    checks++; if (ciq_count !== '0) begin errors++; $display("FAIL t5_count got %0d want 0", ciq_count); end
    idle();
    #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL t5_empty_ready got %b want 1", disp_ready); end
    flush = 1'b1;
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL t5_flush_ready got %b want 0", disp_ready); end
    advance();
    $display("test_illegal done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_random();
    wr_t w;
    int n;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      idle();
      if ($urandom_range(49) == 0) flush = 1'b1;
      issue_grant = DEPTH'($urandom & $urandom) & m_valid;
      alloc();
      if ($urandom_range(7) == 0) free_valid = free_valid & DN'($urandom);
      n = $urandom_range(4);
      disp_valid = DN'((1 << n) - 1);
      set_payload();
      #1;
      checks++;
      if (disp_ready !== exp_ready()) begin
        errors++; $display("FAIL t6_ready cyc %0d got %b want %b", cyc, disp_ready, exp_ready());
      end
      advance();
      checks++;
      if (entry_valid !== m_valid) begin
        errors++; $display("FAIL t6_valid cyc %0d got %h want %h", cyc, entry_valid, m_valid);
      end
      checks++;
      if (ciq_count !== m_count) begin
        errors++; $display("FAIL t6_count cyc %0d got %0d want %0d", cyc, ciq_count, m_count);
      end
      while (sb.size() > 0) begin
        w = sb.pop_front();
        checks++;
        if (entry_payload[w.addr*PW +: PW] !== w.data) begin
          errors++; $display("FAIL t6_payload cyc %0d [%0d] got %h want %h", cyc, w.addr, entry_payload[w.addr*PW +: PW], w.data);
        end
      end
    end
    $display("test_random done: checks %0d errors %0d", checks, errors);
  endtask

  initial begin
    rst_n = 1'b0;
    m_valid = '0;
    m_count = '0;
    disp_payload = '0;
    idle();
    test_reset();
    test_first_group();
    test_near_full();
    test_full_grant();
    test_flush();
    test_illegal();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
